// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and address/twiddle helpers for the
// 64-point radix-2 DIF FFT address sequencer.
package fft_pkg;

    localparam int unsigned N      = 64;
    localparam int unsigned LOG2N  = 6;
    localparam int unsigned BFLIES = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fft_state_t;

    // Mask of the low butterfly-index bits that stay inside one group (span-1).
    function automatic logic [4:0] grp_mask(input logic [2:0] s);
        return 5'(6'd32 >> s) - 5'd1;
    endfunction

    // Top address of butterfly j in stage s; the bottom address is a + span.
    function automatic logic [5:0] bfly_addr(input logic [2:0] s, input logic [4:0] j);
        logic [5:0] w_jj;
        logic [5:0] w_hi;
        w_jj = {1'b0, j};
        w_hi = (w_jj >> (3'd5 - s)) << (3'd6 - s);
        return w_hi | {1'b0, j & grp_mask(s)};
    endfunction

    function automatic logic [5:0] bfly_span(input logic [2:0] s);
        return 6'd32 >> s;
    endfunction

    function automatic logic [4:0] twiddle_exp(input logic [2:0] s, input logic [4:0] j);
        return (j & grp_mask(s)) << s;
    endfunction

    // e = 8q + r  ->  {r[2:0], q[1:0]}
    function automatic logic [4:0] twiddle_ctrl(input logic [4:0] e);
        return {e[2:0], e[4:3]};
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with synchronous clear; used to align write-back
// addresses and twiddle control with the RAM/butterfly pipeline.
module fft_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_wire
        assign o_q = i_d;
    end else begin : g_pipe
        logic [WIDTH-1:0] r_pipe [DEPTH];

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    r_pipe[i] <= '0;
                end
            end else begin
                r_pipe[0] <= i_d;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
        end

        assign o_q = r_pipe[DEPTH-1];
    end

endmodule

// File: rtl/fft_addr_ctrl.sv
// Stage/butterfly sequencer for a 64-point in-place radix-2 DIF FFT: issues read
// pairs, aligned twiddle control, delayed write-back pairs, and drains between stages.
module fft_addr_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned RAM_LAT  = 1,
    parameter int unsigned BFLY_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [2:0] stage,
    output logic       rd_en,
    output logic [5:0] rd_addr_a,
    output logic [5:0] rd_addr_b,
    output logic [4:0] bfpcontrol,
    output logic       wr_en,
    output logic [5:0] wr_addr_a,
    output logic [5:0] wr_addr_b
);

    localparam int unsigned WR_DLY = RAM_LAT + BFLY_LAT;
    localparam int unsigned DRN_W  = (WR_DLY > 1) ? $clog2(WR_DLY) : 1;
    localparam logic [DRN_W-1:0] DRN_LAST   = DRN_W'(WR_DLY - 1);
    localparam logic [2:0]       LAST_STAGE = 3'(LOG2N - 1);
    localparam logic [4:0]       LAST_BFLY  = 5'(BFLIES - 1);

    fft_state_t       r_state;
    logic [2:0]       r_s;
    logic [4:0]       r_j;
    logic [DRN_W-1:0] r_drn;
    logic             r_busy;
    logic             r_done;
    logic             r_rd_en;
    logic [5:0]       r_rd_a;
    logic [5:0]       r_rd_b;
    logic [4:0]       r_tw;

    logic [12:0]      w_wr_in;
    logic [12:0]      w_wr_out;
    logic [4:0]       w_bfp;

    // Read address and twiddle are registered on the same edge that selects the
    // butterfly, so a read issued "in cycle t" is visible on the outputs in cycle t.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_j     <= '0;
            r_drn   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_RUN;
                        r_s     <= '0;
                        r_j     <= '0;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        r_rd_a  <= bfly_addr(3'd0, 5'd0);
                        r_rd_b  <= bfly_addr(3'd0, 5'd0) + bfly_span(3'd0);
                        r_tw    <= twiddle_ctrl(twiddle_exp(3'd0, 5'd0));
                    end
                end
                ST_RUN: begin
                    if (r_j == LAST_BFLY) begin
                        r_state <= ST_DRAIN;
                        r_drn   <= '0;
                        r_rd_en <= 1'b0;
                        r_rd_a  <= '0;
                        r_rd_b  <= '0;
                        r_tw    <= '0;
                    end else begin
                        r_j     <= r_j + 5'd1;
                        r_rd_a  <= bfly_addr(r_s, r_j + 5'd1);
                        r_rd_b  <= bfly_addr(r_s, r_j + 5'd1) + bfly_span(r_s);
                        r_tw    <= twiddle_ctrl(twiddle_exp(r_s, r_j + 5'd1));
                    end
                end
                ST_DRAIN: begin
                    if (r_drn == DRN_LAST) begin
                        if (r_s == LAST_STAGE) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_s     <= r_s + 3'd1;
                            r_j     <= '0;
                            r_rd_en <= 1'b1;
                            r_rd_a  <= bfly_addr(r_s + 3'd1, 5'd0);
                            r_rd_b  <= bfly_addr(r_s + 3'd1, 5'd0) + bfly_span(r_s + 3'd1);
                            r_tw    <= twiddle_ctrl(twiddle_exp(r_s + 3'd1, 5'd0));
                        end
                    end else begin
                        r_drn <= r_drn + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_s     <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_wr_in = {r_rd_en, r_rd_a, r_rd_b};

    fft_delay_line #(
        .WIDTH (13),
        .DEPTH (WR_DLY)
    ) u_wr_dly (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (w_wr_in),
        .o_q     (w_wr_out)
    );

    fft_delay_line #(
        .WIDTH (5),
        .DEPTH (RAM_LAT)
    ) u_bfp_dly (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (r_tw),
        .o_q     (w_bfp)
    );

    assign busy       = r_busy;
    assign done       = r_done;
    assign stage      = r_s;
    assign rd_en      = r_rd_en;
    assign rd_addr_a  = r_rd_a;
    assign rd_addr_b  = r_rd_b;
    assign bfpcontrol = w_bfp;
    assign wr_en      = w_wr_out[12];
    assign wr_addr_a  = w_wr_out[11:6];
    assign wr_addr_b  = w_wr_out[5:0];

endmodule

// File: doc/fft_addr_ctrl.md
# fft_addr_ctrl

Sequencer for the 64-point in-place radix-2 decimation-in-frequency (DIF) FFT. It runs 6 stages of 32 butterflies each over a dual-port sample RAM. For each butterfly it issues the pair of read addresses, drives the butterfly's 5-bit twiddle control (`bfpcontrol`) aligned with the returning RAM data, and issues the write-back addresses after the combined RAM and butterfly latency. Between stages it drains the pipeline so every stage reads fully written data.

## Interface
- `RAM_LAT`, 1: cycles from `rd_en`/address to read data at the butterfly inputs.
- `BFLY_LAT`, 2: cycles from butterfly input to `write_data_a`/`write_data_b` valid.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `busy` out 1: high from the first read through the last write.
- `done` out 1: one-cycle pulse after the last write.
- `stage` out 3: current stage, 0..5 (0 when idle).
- `rd_en` out 1: read strobe for both RAM ports.
- `rd_addr_a`, `rd_addr_b` out 6 each: butterfly top and bottom read addresses.
- `bfpcontrol` out 5: twiddle select for the butterfly. `[4:2]` is r and `[1:0]` is q.
- `wr_en` out 1: write strobe for both RAM ports.
- `wr_addr_a`, `wr_addr_b` out 6 each: write-back addresses for the a+b and (a−b)·W results.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN when `start`=1. Counters are cleared on this transition: stage s=0 and butterfly index j=0.
- RUN: one butterfly per cycle, j = 0..31.
  - Each cycle drives `rd_en`=1, `rd_addr_a`=a and `rd_addr_b`=a+span.
  - span = 32>>s.
  - a = ((j>>(5−s))<<(6−s)) | (j & (span−1)).
  - After j=31 the FSM goes to DRAIN.
- DRAIN: holds for WR_DLY = RAM_LAT+BFLY_LAT cycles with no reads issued.
  - If s<5: s increments and the FSM returns to RUN with j=0.
  - If s=5: the FSM goes to DONE.
- DONE: pulses `done` for one cycle, then returns to IDLE.
- Twiddle exponent e = (j & (span−1)) << s, range 0..31.
  - It splits as e = 8q + r.
  - `bfpcontrol` = {r[2:0], q[1:0]}.
  - Meaning: q=0 selects none, q=1 selects W8, q=2 selects W16, q=3 selects W24.
- `bfpcontrol` passes through a RAM_LAT-deep register chain so it is valid alongside the read data. It is 0 on cycles with no valid data.
- Write path: {valid, a, b} goes through a WR_DLY-deep delay line. Its output drives `wr_en`, `wr_addr_a` and `wr_addr_b` directly.
- `start` while not in IDLE is ignored.
- Output ordering: results end in bit-reversed order. Reordering is not this block's job.

## Timing
- Reset values: all outputs 0 and FSM in IDLE. The delay lines and bfpcontrol chain are cleared.
- Reset mid-transform: the transform is abandoned and pending writes are dropped. No `wr_en` appears after reset.
- `start` sampled high at cycle 0 (defaults RAM_LAT=1, BFLY_LAT=2, WR_DLY=3):
  - Stage k reads occupy cycles 1+35k .. 32+35k.
  - Each stage's writes lag its reads by exactly 3 cycles.
  - The last read is at cycle 207 and the last write at cycle 210.
  - `done`=1 in cycle 211 only.
- `busy`=1 in cycles 1..210 and 0 during the `done` cycle.
- No read of stage k+1 occurs before the cycle after the final write of stage k. This holds because DRAIN = WR_DLY.
- `bfpcontrol` for a read issued at cycle t is valid in cycle t+RAM_LAT.
- `wr_en` for that read is at cycle t+WR_DLY.
- `start` asserted in the DONE cycle is ignored. `start` in the following IDLE cycle begins a new transform.

## Structure
- Shared package `fft_pkg`:
  - Constants N=64, LOG2N=6, BFLIES=32.
  - The FSM state enum.
  - Function `twiddle_ctrl(e[4:0])` returning 5-bit `bfpcontrol`.
- Sub-module `fft_delay_line`:
  - Parameters WIDTH and DEPTH; synchronous reset to 0.
  - Instantiated once for {valid, a, b} (13 bits, DEPTH=WR_DLY).
  - Instantiated once for `bfpcontrol` (5 bits, DEPTH=RAM_LAT).
- Counters: 3-bit stage counter, 5-bit butterfly counter, drain counter sized for WR_DLY.

## Test plan
- Reset, then idle 10 cycles → all outputs 0 and no `rd_en`/`wr_en`. `start` pulsed while `reset`=1 → no activity.
- `start` at cycle 0:
  - cycle 1: `rd_addr_a`=0, `rd_addr_b`=32.
  - cycle 2: `bfpcontrol`=0x00.
  - cycle 4: `wr_addr_a`=0, `wr_addr_b`=32.
  - s=0, j=5 → a=5, b=37, `bfpcontrol`=0x14.
  - s=0, j=13 → a=13, b=45, `bfpcontrol`=0x15.
- s=1, j=3 → a=3, b=19, `bfpcontrol`=0x18. s=1, j=16 → a=32, b=48, `bfpcontrol`=0x00.
- s=2, j=7 → a=7, b=15, `bfpcontrol`=0x13. s=5, all j → a=2j, b=2j+1, `bfpcontrol`=0x00.
- Full run:
  - Exactly 192 `rd_en` and 192 `wr_en` cycles.
  - Last write at cycle 210, `done` at 211.
  - `start` pulses at cycles 50 and 211 are ignored.
  - A scoreboard confirms no read hits an address with a pending write.
- `reset` at cycle 100 (mid stage 2) → outputs 0 from cycle 101 with no further `wr_en`. A new `start` then reproduces the full-run timing exactly.
